e203_mvu_apb_arb: RTL and testbench
===================================

// Module: e203_mvu_apb_arb
// PURPOSE
//  Shares the single MVU APB config port (mvu_apb_*) among N_REQ ICB requesters
//  (core sysper path, debug, DMA). Round-robin arbitration, ICB-to-APB conversion,
//  one outstanding transfer at a time. Sits in e203_subsys between the ICB
//  fabric and the mvu_apb_* SoC outputs.
// PARAMETERS
//  N_REQ      2             number of ICB requesters (>=2)
//  ADDR_BASE  32'h1004_0000 MVU window base; hit = (cmd_addr & ~ADDR_MASK) == ADDR_BASE
//  ADDR_MASK  32'h0000_0FFF offset bits inside window; paddr = cmd_addr & ADDR_MASK
// PORTS
//  clk            in   1        core clock
//  rst            in   1        synchronous reset, active-high
//  req_cmd_valid  in   N_REQ    per-requester ICB command valid
//  req_cmd_ready  out  N_REQ    per-requester ICB command ready (one-hot or 0)
//  req_cmd_addr   in   32*N_REQ packed addresses, requester i at [32*i+:32]
//  req_cmd_read   in   N_REQ    1=read, 0=write
//  req_cmd_wdata  in   32*N_REQ packed write data
//  req_cmd_wmask  in   4*N_REQ  packed byte masks
//  req_rsp_valid  out  N_REQ    response valid (one-hot or 0)
//  req_rsp_ready  in   N_REQ    response ready
//  req_rsp_err    out  1        error flag, valid with any req_rsp_valid bit
//  req_rsp_rdata  out  32       read data, valid with any req_rsp_valid bit
//  mvu_apb_paddr  out  32       APB address
//  mvu_apb_pwrite out  1        APB write
//  mvu_apb_pselx  out  1        APB select
//  mvu_apb_penable out 1        APB enable
//  mvu_apb_pwdata out  32       APB write data
//  mvu_apb_prdata in   32       APB read data (no pready: MVU is zero-wait)
// BEHAVIOUR
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE; IDLE -> RESP on error.
//  - Reset: state=IDLE, all outputs 0, rr pointer last=N_REQ-1 (req 0 wins first).
//  - IDLE: winner = first valid requester at index > last (wrapping). Winner's
//    req_cmd_ready=1 combinationally in same cycle; cmd captured, last<=winner.
//    No valid -> all ready 0, stay IDLE.
//  - Error = window miss OR (write AND wmask!=4'hF); goes IDLE->RESP, err=1,
//    rdata=0, no APB activity.
//  - SETUP: pselx=1, penable=0, paddr/pwrite/pwdata from capture (pwdata=0 on read).
//  - ACCESS: pselx=1, penable=1, addr/data held; prdata registered at end of cycle.
//  - RESP: rsp_valid bit of granted requester=1, err/rdata stable until that
//    requester's rsp_ready=1; then IDLE. APB outputs all 0 outside SETUP/ACCESS.
//  - Latency accept(T) -> SETUP T+1 -> ACCESS T+2 -> rsp_valid T+3; min 4 cycles
//    per transfer; next accept earliest in cycle after rsp handshake.
//  - Requesters not granted see cmd_ready=0 throughout; no starvation: each
//    valid requester served within N_REQ transfers.
//  - Simultaneous rsp_ready from non-granted requesters ignored.
//  - Reset mid-transfer: transfer abandoned, no response issued, APB idle next cycle.
// TESTING
//  1 Single write req0 addr 0x1004_0010 data 0xDEAD_BEEF mask F -> T+1 psel=1
//    pen=0 paddr=0x010 pwrite=1; T+2 pen=1; T+3 rsp_valid[0]=1 err=0.
//  2 Read req1 addr 0x1004_0020, prdata=0x1234_5678 in ACCESS -> rsp_rdata
//    =0x1234_5678, err=0, rsp_valid[1] only.
//  3 req0,req1 valid continuously from reset -> grants 0,1,0,1; never two
//    cmd_ready bits high.
//  4 Write addr 0x2000_0000 or mask 4'h3 -> rsp_valid at T+1, err=1, pselx never 1.
//  5 rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, no new cmd_ready,
//    pselx=0.
//  6 rst asserted during ACCESS -> next cycle all outputs 0, no rsp; req0 next wins.

Source files
------------

// File: rtl/e203_mvu_apb_arb_if.sv
// Bundle of the N_REQ ICB requester ports and the MVU APB config port.
// The arbiter uses the slave modport; the requesters/APB target side uses master.
interface e203_mvu_apb_arb_if #(
  parameter int unsigned N_REQ = 2
);
  logic [N_REQ-1:0]    req_cmd_valid;
  logic [N_REQ-1:0]    req_cmd_ready;
  logic [32*N_REQ-1:0] req_cmd_addr;
  logic [N_REQ-1:0]    req_cmd_read;
  logic [32*N_REQ-1:0] req_cmd_wdata;
  logic [4*N_REQ-1:0]  req_cmd_wmask;
  logic [N_REQ-1:0]    req_rsp_valid;
  logic [N_REQ-1:0]    req_rsp_ready;
  logic                req_rsp_err;
  logic [31:0]         req_rsp_rdata;
  logic [31:0]         mvu_apb_paddr;
  logic                mvu_apb_pwrite;
  logic                mvu_apb_pselx;
  logic                mvu_apb_penable;
  logic [31:0]         mvu_apb_pwdata;
  logic [31:0]         mvu_apb_prdata;

  modport slave (
    input  req_cmd_valid, req_cmd_addr, req_cmd_read, req_cmd_wdata, req_cmd_wmask,
    input  req_rsp_ready, mvu_apb_prdata,
    output req_cmd_ready, req_rsp_valid, req_rsp_err, req_rsp_rdata,
    output mvu_apb_paddr, mvu_apb_pwrite, mvu_apb_pselx, mvu_apb_penable, mvu_apb_pwdata
  );

  modport master (
    output req_cmd_valid, req_cmd_addr, req_cmd_read, req_cmd_wdata, req_cmd_wmask,
    output req_rsp_ready, mvu_apb_prdata,
    input  req_cmd_ready, req_rsp_valid, req_rsp_err, req_rsp_rdata,
    input  mvu_apb_paddr, mvu_apb_pwrite, mvu_apb_pselx, mvu_apb_penable, mvu_apb_pwdata
  );
endinterface

// File: rtl/e203_mvu_apb_arb.sv
// Round-robin arbiter sharing the MVU APB config port among N_REQ ICB requesters.
// One transfer outstanding; ICB command converted to a zero-wait APB SETUP/ACCESS pair.
module e203_mvu_apb_arb #(
  parameter int unsigned N_REQ     = 2,
  parameter logic [31:0] ADDR_BASE = 32'h1004_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_0FFF
) (
  input logic               clk,
  input logic               rst,
  e203_mvu_apb_arb_if.slave bus
);
  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] last_q, gnt_q;
  logic [31:0]     paddr_q, pwdata_q, rdata_q;
  logic            write_q, err_q;

  logic [IdxW-1:0] win_idx, cand;
  logic            win_found, accept, win_read, win_err;
  logic [31:0]     win_addr, win_wdata;
  logic [3:0]      win_wmask;

  // Round-robin search: first valid requester strictly after the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % N_REQ);
      if (!win_found && bus.req_cmd_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select the winner's command fields and classify it
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_wmask = '0;
    win_read  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IdxW'(i)) begin
        win_addr  = bus.req_cmd_addr[32*i +: 32];
        win_wdata = bus.req_cmd_wdata[32*i +: 32];
        win_wmask = bus.req_cmd_wmask[4*i +: 4];
        win_read  = bus.req_cmd_read[i];
      end
    end
    // Window miss or partial write is answered locally without touching APB
    win_err = ((win_addr & ~ADDR_MASK) != ADDR_BASE) || (!win_read && (win_wmask != 4'hF));
    accept  = (state_q == StIdle) && win_found && !rst;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = win_err ? StResp : StSetup;
      StSetup:  state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   if (bus.req_rsp_ready[gnt_q]) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State, round-robin pointer and captured command/response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= IdxW'(N_REQ - 1);
      gnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q   <= win_idx;
        gnt_q    <= win_idx;
        paddr_q  <= win_addr & ADDR_MASK;
        write_q  <= !win_read;
        pwdata_q <= win_read ? 32'h0 : win_wdata;
        err_q    <= win_err;
        rdata_q  <= '0;
      end
      if (state_q == StAccess) rdata_q <= bus.mvu_apb_prdata;
    end
  end

  // Output decode: APB driven only in SETUP/ACCESS, response only in RESP
  always_comb begin
    bus.req_cmd_ready   = '0;
    bus.req_rsp_valid   = '0;
    bus.req_rsp_err     = 1'b0;
    bus.req_rsp_rdata   = '0;
    bus.mvu_apb_paddr   = '0;
    bus.mvu_apb_pwrite  = 1'b0;
    bus.mvu_apb_pselx   = 1'b0;
    bus.mvu_apb_penable = 1'b0;
    bus.mvu_apb_pwdata  = '0;
    if (accept) bus.req_cmd_ready = N_REQ'(1) << win_idx;
    if ((state_q == StSetup) || (state_q == StAccess)) begin
      bus.mvu_apb_pselx   = 1'b1;
      bus.mvu_apb_penable = (state_q == StAccess);
      bus.mvu_apb_paddr   = paddr_q;
      bus.mvu_apb_pwrite  = write_q;
      bus.mvu_apb_pwdata  = pwdata_q;
    end
    if (state_q == StResp) begin
      bus.req_rsp_valid = N_REQ'(1) << gnt_q;
      bus.req_rsp_err   = err_q;
      bus.req_rsp_rdata = rdata_q;
    end
  end
endmodule

// File: tb/tb_e203_mvu_apb_arb.sv
// Bench for e203_mvu_apb_arb: transaction-level model (age since accept) checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_e203_mvu_apb_arb;
  localparam int unsigned N    = 2;
  localparam logic [31:0] BASE = 32'h1004_0000;
  localparam logic [31:0] MASK = 32'h0000_0FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  e203_mvu_apb_arb_if #(.N_REQ(N)) bus ();

  e203_mvu_apb_arb #(.N_REQ(N), .ADDR_BASE(BASE), .ADDR_MASK(MASK)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  // Transaction model
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_gnt = 0;
  int          m_last = N - 1;
  bit          m_err = 1'b0;
  bit          m_write = 1'b0;
  logic [31:0] m_paddr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (bus.req_cmd_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_resp();
    return m_busy && (m_err || m_age >= 3);
  endfunction

  task automatic compare();
    int w;
    logic [N-1:0] er, ev;
    bit setup, access;
    w = (!m_busy && !rst) ? winner() : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    ev = '0;
    if (m_resp()) ev[m_gnt] = 1'b1;
    setup  = m_busy && !m_err && m_age == 1;
    access = m_busy && !m_err && m_age == 2;
    chk("cmd_ready", 32'(bus.req_cmd_ready), 32'(er));
    chk("rsp_valid", 32'(bus.req_rsp_valid), 32'(ev));
    if (m_resp()) begin
      chk("rsp_err", 32'(bus.req_rsp_err), 32'(m_err));
      chk("rsp_rdata", bus.req_rsp_rdata, m_err ? 32'h0 : m_rdata);
    end
    chk("pselx", 32'(bus.mvu_apb_pselx), 32'(setup || access));
    chk("penable", 32'(bus.mvu_apb_penable), 32'(access));
    chk("paddr", bus.mvu_apb_paddr, (setup || access) ? m_paddr : 32'h0);
    chk("pwrite", 32'(bus.mvu_apb_pwrite), 32'((setup || access) && m_write));
    chk("pwdata", bus.mvu_apb_pwdata, (setup || access) ? m_wdata : 32'h0);
  endtask

  task automatic update();
    int w;
    logic [31:0] a;
    bit rd;
    if (rst) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else if (!m_busy) begin
      w = winner();
      if (w >= 0) begin
        a       = bus.req_cmd_addr[32*w +: 32];
        rd      = bus.req_cmd_read[w];
        m_busy  = 1'b1;
        m_age   = 1;
        m_gnt   = w;
        m_last  = w;
        m_err   = ((a & ~MASK) != BASE) || (!rd && bus.req_cmd_wmask[4*w +: 4] != 4'hF);
        m_paddr = a & MASK;
        m_write = !rd;
        m_wdata = rd ? 32'h0 : bus.req_cmd_wdata[32*w +: 32];
        m_rdata = '0;
      end
    end else if (m_resp()) begin
      if (bus.req_rsp_ready[m_gnt]) m_busy = 1'b0;
    end else begin
      if (m_age == 2) m_rdata = bus.mvu_apb_prdata;
      m_age++;
    end
  endtask

  // One clock: check at negedge, advance model at posedge, return just after it
  task automatic cycle();
    @(negedge clk);
    if (armed) compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [31:0] a, input bit rd,
                         input logic [31:0] wd, input logic [3:0] wm);
    bus.req_cmd_valid[i]        = v;
    bus.req_cmd_addr[32*i +: 32] = a;
    bus.req_cmd_read[i]         = rd;
    bus.req_cmd_wdata[32*i +: 32] = wd;
    bus.req_cmd_wmask[4*i +: 4]  = wm;
  endtask

  task automatic clear_all();
    bus.req_cmd_valid  = '0;
    bus.req_cmd_addr   = '0;
    bus.req_cmd_read   = '0;
    bus.req_cmd_wdata  = '0;
    bus.req_cmd_wmask  = '0;
    bus.req_rsp_ready  = '0;
    bus.mvu_apb_prdata = '0;
  endtask

  int grants[$];

  initial begin
    clear_all();
    rst = 1'b1;
    cycle();
    armed = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.req_cmd_ready), 32'h0);
    chk("rst_pselx", 32'(bus.mvu_apb_pselx), 32'h0);
    chk("rst_rsp_valid", 32'(bus.req_rsp_valid), 32'h0);

    // 1: single write from req0
    set_req(0, 1'b1, 32'h1004_0010, 1'b0, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("t1_ready", 32'(bus.req_cmd_ready), 32'h1);
    cycle();
    chk("t1_pselx", 32'(bus.mvu_apb_pselx), 32'h1);
    chk("t1_penable", 32'(bus.mvu_apb_penable), 32'h0);
    chk("t1_paddr", bus.mvu_apb_paddr, 32'h0000_0010);
    chk("t1_pwrite", 32'(bus.mvu_apb_pwrite), 32'h1);
    chk("t1_pwdata", bus.mvu_apb_pwdata, 32'hDEAD_BEEF);
    bus.req_cmd_valid = '0;
    cycle();
    chk("t1_penable2", 32'(bus.mvu_apb_penable), 32'h1);
    cycle();
    chk("t1_rsp_valid", 32'(bus.req_rsp_valid), 32'h1);
    chk("t1_rsp_err", 32'(bus.req_rsp_err), 32'h0);
    bus.req_rsp_ready = 2'b01;
    cycle();
    bus.req_rsp_ready = '0;

    // 2: read from req1 returns prdata sampled in ACCESS
    set_req(1, 1'b1, 32'h1004_0020, 1'b1, 32'h0, 4'h0);
    #1;
    chk("t2_ready", 32'(bus.req_cmd_ready), 32'h2);
    cycle();
    bus.req_cmd_valid = '0;
    cycle();
    bus.mvu_apb_prdata = 32'h1234_5678;
    cycle();
    bus.mvu_apb_prdata = 32'h0;
    chk("t2_rsp_valid", 32'(bus.req_rsp_valid), 32'h2);
    chk("t2_rdata", bus.req_rsp_rdata, 32'h1234_5678);
    chk("t2_err", 32'(bus.req_rsp_err), 32'h0);
    bus.req_rsp_ready = 2'b10;
    cycle();
    bus.req_rsp_ready = '0;

    // 3: both requesters valid from reset alternate 0,1,0,1
    rst = 1'b1;
    set_req(0, 1'b1, 32'h1004_0004, 1'b1, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h1004_0008, 1'b1, 32'h0, 4'h0);
    bus.req_rsp_ready = 2'b11;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (bus.req_cmd_ready == 2'b01) grants.push_back(0);
      else if (bus.req_cmd_ready == 2'b10) grants.push_back(1);
      cycle();
    end
    chk("t3_ngrants", 32'(grants.size() >= 4), 32'h1);
    for (int g = 0; g < 4 && g < grants.size(); g++) chk("t3_grant", 32'(grants[g]), 32'(g % 2));
    clear_all();
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // 4: window miss and partial write are errors with no APB activity
    set_req(0, 1'b1, 32'h2000_0000, 1'b0, 32'h1111_1111, 4'hF);
    #1;
    chk("t4_ready", 32'(bus.req_cmd_ready), 32'h1);
    cycle();
    bus.req_cmd_valid = '0;
    chk("t4_rsp_valid", 32'(bus.req_rsp_valid), 32'h1);
    chk("t4_err", 32'(bus.req_rsp_err), 32'h1);
    chk("t4_rdata", bus.req_rsp_rdata, 32'h0);
    chk("t4_pselx", 32'(bus.mvu_apb_pselx), 32'h0);
    bus.req_rsp_ready = 2'b01;
    cycle();
    bus.req_rsp_ready = '0;
    set_req(1, 1'b1, 32'h1004_0040, 1'b0, 32'h2222_2222, 4'h3);
    cycle();
    bus.req_cmd_valid = '0;
    chk("t4b_rsp_valid", 32'(bus.req_rsp_valid), 32'h2);
    chk("t4b_err", 32'(bus.req_rsp_err), 32'h1);
    chk("t4b_pselx", 32'(bus.mvu_apb_pselx), 32'h0);
    bus.req_rsp_ready = 2'b10;
    cycle();
    bus.req_rsp_ready = '0;

    // 5: response stalled; other requester waits, non-granted rsp_ready ignored
    set_req(0, 1'b1, 32'h1004_0080, 1'b1, 32'h0, 4'h0);
    cycle();
    bus.req_cmd_valid = '0;
    set_req(1, 1'b1, 32'h1004_0084, 1'b1, 32'h0, 4'h0);
    cycle();
    bus.mvu_apb_prdata = 32'hA5A5_0001;
    cycle();
    bus.req_rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      bus.mvu_apb_prdata = $urandom;
      #1;
      chk("t5_rsp_valid", 32'(bus.req_rsp_valid), 32'h1);
      chk("t5_rdata", bus.req_rsp_rdata, 32'hA5A5_0001);
      chk("t5_ready", 32'(bus.req_cmd_ready), 32'h0);
      chk("t5_pselx", 32'(bus.mvu_apb_pselx), 32'h0);
      cycle();
    end
    bus.req_rsp_ready = 2'b01;
    cycle();
    clear_all();
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // 6: reset during ACCESS abandons the transfer
    set_req(0, 1'b1, 32'h1004_0100, 1'b0, 32'h5555_AAAA, 4'hF);
    cycle();
    bus.req_cmd_valid = '0;
    cycle();
    chk("t6_access", 32'(bus.mvu_apb_penable), 32'h1);
    rst = 1'b1;
    set_req(0, 1'b1, 32'h1004_0104, 1'b1, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h1004_0108, 1'b1, 32'h0, 4'h0);
    cycle();
    chk("t6_pselx", 32'(bus.mvu_apb_pselx), 32'h0);
    chk("t6_penable", 32'(bus.mvu_apb_penable), 32'h0);
    chk("t6_paddr", bus.mvu_apb_paddr, 32'h0);
    chk("t6_rsp_valid", 32'(bus.req_rsp_valid), 32'h0);
    chk("t6_ready_in_rst", 32'(bus.req_cmd_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("t6_req0_wins", 32'(bus.req_cmd_ready), 32'h1);
    cycle();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 99) < 85) ? (BASE | ($urandom & MASK)) : $urandom;
        set_req(i, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 99) < 80) ? 4'hF : 4'($urandom));
        bus.req_rsp_ready[i] = ($urandom_range(0, 99) < 70);
      end
      bus.mvu_apb_prdata = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    clear_all();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
